// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone instruction/data memory arbiter.
// Holds FSM state encodings, grant history and the round-robin pick rule.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    INSTR,
    DATA
  } grant_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned TIMEOUT_W =
    $clog2(TIMEOUT_CYCLES_DEF + 1);

  // Whoever was not served last wins; no history falls back to data_first.
  function automatic grant_t rr_pick(
    input grant_t last,
    input logic   data_first
  );
    case (last)
      INSTR:   return DATA;
      DATA:    return INSTR;
      default: return data_first ? DATA : INSTR;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer watchdog: counts granted cycles without s_ack.
// Built only when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF,
  parameter int unsigned W     = TIMEOUT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expire = active && !ack && (cnt_q == LIM);

  // Any non-granted cycle zeroes the count, so entry always starts at 0.
  always_comb begin
    cnt_d = '0;
    if (active && !ack && !expire)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory port between m0/m1.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter bit          DATA_FIRST     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack
);

  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;
  logic       req0, req1, gnt_i, gnt_d, expire;

  assign req0  = m0_cyc & m0_stb;
  assign req1  = m1_cyc & m1_stb;
  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TW     = (TW_RAW < 8) ? 8 : TW_RAW;

  wb_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TW)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (gnt_i | gnt_d),
    .ack    (s_ack),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign expire         = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= NONE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)
          state_d = (rr_pick(last_q, DATA_FIRST) == DATA)
                  ? GNT_D : GNT_I;
        else if (req1)
          state_d = GNT_D;
        else if (req0)
          state_d = GNT_I;
      end
      GNT_I: begin
        if (s_ack || expire) begin
          state_d = IDLE;
          last_d  = INSTR;
        end else if (!m0_cyc) begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        if (s_ack || expire) begin
          state_d = IDLE;
          last_d  = DATA;
        end else if (!m1_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the registered state, so reset clears them at once.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_addr    = '0;
    s_data_o  = '0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_data_o = '0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_data_o = '0;
    if (gnt_i) begin
      s_cyc    = m0_cyc & ~expire;
      s_stb    = m0_stb & ~expire;
      s_we     = m0_we;
      s_addr   = m0_addr;
      s_data_o = m0_data_i;
      m0_ack   = s_ack;
      m0_err   = expire;
      if (s_ack) m0_data_o = s_data_i;
    end
    if (gnt_d) begin
      s_cyc    = m1_cyc & ~expire;
      s_stb    = m1_stb & ~expire;
      s_we     = m1_we;
      s_addr   = m1_addr;
      s_data_o = m1_data_i;
      m1_ack   = s_ack;
      m1_err   = expire;
      if (s_ack) m1_data_o = s_data_i;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus
// randomized masters/slave checked against a bus-ownership model.
module tb_wb_mem_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_addr, m0_data_i, m0_data_o;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_addr, m1_data_i, m1_data_o;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_data_o, s_data_i;
  logic        s_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .DATA_FIRST     (1'b1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_data_i (m0_data_i),
    .m0_data_o (m0_data_o),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_data_i (m1_data_i),
    .m1_data_o (m1_data_o),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_data_o  (s_data_o),
    .s_data_i  (s_data_i),
    .s_ack     (s_ack)
  );

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m0_addr = '0; m0_data_i = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    m1_addr = '0; m1_data_i = '0;
    s_ack = 0; s_data_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic req0(input logic [31:0] a, input logic w,
                      input logic [31:0] d);
    m0_cyc = 1; m0_stb = 1; m0_we = w;
    m0_addr = a; m0_data_i = d;
  endtask

  task automatic req1(input logic [31:0] a, input logic w,
                      input logic [31:0] d);
    m1_cyc = 1; m1_stb = 1; m1_we = w;
    m1_addr = a; m1_data_i = d;
  endtask

  task automatic test_reset();
    rst = 1;
    req0(32'h1234, 1, 32'h55);
    req1(32'h5678, 1, 32'h66);
    s_ack = 1; s_data_i = 32'hFFFF_FFFF;
    #3;
    n_cmp++;
    if ({s_cyc, s_stb, s_we} !== 3'b000)
      $display("FAIL rst_sctl: got %b want 000",
               {s_cyc, s_stb, s_we});
    n_cmp++;
    if (s_addr !== 32'h0)
      $display("FAIL rst_saddr: got %h want 0", s_addr);
    n_cmp++;
    if (s_data_o !== 32'h0)
      $display("FAIL rst_sdata: got %h want 0", s_data_o);
    n_cmp++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000)
      $display("FAIL rst_ack: got %b want 0000",
               {m0_ack, m0_err, m1_ack, m1_err});
    n_cmp++;
    if ({m0_data_o, m1_data_o} !== 64'h0)
      $display("FAIL rst_mdata: got %h want 0",
               {m0_data_o, m1_data_o});
    if (n_cmp - 5 < 0) n_bad++;
    n_bad += (s_cyc !== 1'b0) + (s_addr !== 32'h0)
           + (s_data_o !== 32'h0)
           + ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0)
           + ({m0_data_o, m1_data_o} !== 64'h0);
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    req0(32'h10, 0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (s_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL sr_latency: s_cyc got %b want 0", s_cyc);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_stb, s_addr} !== {2'b11, 32'h10}) begin
      n_bad++;
      $display("FAIL sr_req: got %b%b %h want 11 10",
               s_cyc, s_stb, s_addr);
    end
    step();
    s_ack = 1; s_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({m0_ack, m0_data_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL sr_ack: got %b %h want 1 deadbeef",
               m0_ack, m0_data_o);
    end
    n_cmp++;
    if ({m1_ack, m1_data_o} !== 33'h0) begin
      n_bad++;
      $display("FAIL sr_other: got %b %h want 0 0",
               m1_ack, m1_data_o);
    end
    step();
    idle_all();
    @(negedge clk);
    n_cmp++;
    if (s_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL sr_idle: s_cyc got %b want 0", s_cyc);
    end
  endtask

  task automatic test_both();
    do_reset();
    req0(32'h200, 0, 32'h0);
    req1(32'h100, 1, 32'hA5A5_A5A5);
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_we, s_addr, s_data_o} !==
        {2'b11, 32'h100, 32'hA5A5_A5A5}) begin
      n_bad++;
      $display("FAIL both_first: got %b%b %h %h want 11 100 a5a5a5a5",
               s_cyc, s_we, s_addr, s_data_o);
    end
    step();
    s_ack = 1;
    @(negedge clk);
    n_cmp++;
    if ({m1_ack, m0_ack} !== 2'b10) begin
      n_bad++;
      $display("FAIL both_ack1: got %b%b want 10", m1_ack, m0_ack);
    end
    step();
    s_ack = 0;
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    n_cmp++;
    if (s_cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL both_idle: s_cyc got %b want 0", s_cyc);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_we, s_addr} !== {2'b10, 32'h200}) begin
      n_bad++;
      $display("FAIL both_second: got %b%b %h want 10 200",
               s_cyc, s_we, s_addr);
    end
    step();
    s_ack = 1; s_data_i = 32'h0BAD_F00D;
    @(negedge clk);
    n_cmp++;
    if ({m0_ack, m0_data_o} !== {1'b1, 32'h0BAD_F00D}) begin
      n_bad++;
      $display("FAIL both_ack0: got %b %h want 1 0badf00d",
               m0_ack, m0_data_o);
    end
    step();
    idle_all();
  endtask

  task automatic test_back_to_back();
    int got = 0;
    do_reset();
    req0(32'h40, 0, 32'h0);
    req1(32'h80, 0, 32'h0);
    for (int c = 0; c < 40 && got < 6; c++) begin
      step();
      s_ack = s_cyc & s_stb;
      s_data_i = $urandom;
      @(negedge clk);
      if (m0_ack && m1_ack) begin
        n_cmp++; n_bad++;
        $display("FAIL b2b_dual: both acks high at cycle %0d", c);
      end else if (m1_ack || m0_ack) begin
        n_cmp++;
        if (m1_ack !== (got % 2 == 0)) begin
          n_bad++;
          $display("FAIL b2b_order: grant %0d got m1=%b want %b",
                   got, m1_ack, (got % 2 == 0));
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 6) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d grants want 6", got);
    end
    step();
    idle_all();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req1(32'h300, 1, 32'h77);
    step();
    s_ack = 1;
    step();
    s_ack = 0;
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_stb, s_addr} !== {1'b1, 32'h300}) begin
      n_bad++;
      $display("FAIL rm_pre: got %b %h want 1 300", s_stb, s_addr);
    end
    #2;
    s_ack = 1;
    rst = 1;
    #1;
    n_cmp++;
    if ({s_cyc, s_stb, m0_ack, m1_ack} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rm_clear: got %b want 0000",
               {s_cyc, s_stb, m0_ack, m1_ack});
    end
    n_cmp++;
    if (m1_data_o !== 32'h0) begin
      n_bad++;
      $display("FAIL rm_data: got %h want 0", m1_data_o);
    end
    s_ack = 0;
    step();
    rst = 0;
    req0(32'h400, 0, 32'h0);
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_addr} !== {1'b1, 32'h300}) begin
      n_bad++;
      $display("FAIL rm_first: got %b %h want 1 300", s_cyc, s_addr);
    end
    step();
    idle_all();
  endtask

  task automatic test_abort();
    do_reset();
    req1(32'h500, 0, 32'h0);
    step();
    req0(32'h600, 0, 32'h0);
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_addr} !== {1'b1, 32'h500}) begin
      n_bad++;
      $display("FAIL ab_pre: got %b %h want 1 500", s_cyc, s_addr);
    end
    step();
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, m1_ack} !== 2'b00) begin
      n_bad++;
      $display("FAIL ab_drop: got %b%b want 00", s_cyc, m1_ack);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, m1_ack, m0_ack} !== 3'b000) begin
      n_bad++;
      $display("FAIL ab_idle: got %b want 000",
               {s_cyc, m1_ack, m0_ack});
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_addr} !== {1'b1, 32'h600}) begin
      n_bad++;
      $display("FAIL ab_next: got %b %h want 1 600", s_cyc, s_addr);
    end
    step();
    idle_all();
  endtask

  task automatic test_timeout();
    do_reset();
    req0(32'h700, 0, 32'h0);
`ifdef WB_ARB_TIMEOUT_EN
    begin
      int errs  = 0;
      int first = -1;
      int d_at  = -1;
      for (int c = 1; c <= 12; c++) begin
        step();
        if (c == 2) req1(32'h800, 0, 32'h0);
        if (d_at > 0) begin
          m1_cyc = 0; m1_stb = 0;
        end
        @(negedge clk);
        if (m0_err) begin
          errs++;
          if (first < 0) first = c;
          n_cmp++;
          if (s_stb !== 1'b0) begin
            n_bad++;
            $display("FAIL to_stb: got %b want 0", s_stb);
          end
        end
        if (s_cyc && s_addr == 32'h800 && d_at < 0) d_at = c;
      end
      n_cmp++;
      if (errs != 1) begin
        n_bad++;
        $display("FAIL to_errs: got %0d want 1", errs);
      end
      n_cmp++;
      if (first != TO + 1) begin
        n_bad++;
        $display("FAIL to_when: got %0d want %0d", first, TO + 1);
      end
      n_cmp++;
      if (d_at != TO + 3) begin
        n_bad++;
        $display("FAIL to_m1: got %0d want %0d", d_at, TO + 3);
      end
    end
`else
    step();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({s_cyc, s_addr, m0_err, m1_err} !==
          {1'b1, 32'h700, 2'b00}) begin
        n_bad++;
        $display("FAIL to_hold: cyc %0d got %b %h %b%b want 1 700 00",
                 c, s_cyc, s_addr, m0_err, m1_err);
      end
      step();
    end
`endif
    idle_all();
    step();
  endtask

  task automatic test_random();
    int          owner = -1;
    int          last  = -1;
    int          wait_n = 0;
    logic        act[2];
    logic        got[2];
    logic        w[2];
    logic [31:0] a[2];
    logic [31:0] wd[2];
    logic        e_cyc, e_we, e_ack0, e_ack1;
    logic [31:0] e_addr, e_wd;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; got[k] = 0; w[k] = 0;
      a[k] = '0; wd[k] = '0;
    end
    for (int c = 0; c < 800; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (got[k]) act[k] = 0;
        else if (act[k] && $urandom_range(0, 29) == 0) act[k] = 0;
        got[k] = 0;
        if (!act[k] && $urandom_range(0, 2) == 0) begin
          act[k] = 1;
          a[k]   = $urandom;
          w[k]   = 1'($urandom);
          wd[k]  = $urandom;
        end
      end
      m0_cyc = act[0]; m0_stb = act[0]; m0_we = w[0];
      m0_addr = a[0]; m0_data_i = wd[0];
      m1_cyc = act[1]; m1_stb = act[1]; m1_we = w[1];
      m1_addr = a[1]; m1_data_i = wd[1];
      e_cyc  = (owner >= 0) ? act[owner] : 1'b0;
      e_we   = (owner >= 0) ? w[owner] : 1'b0;
      e_addr = (owner >= 0) ? a[owner] : 32'h0;
      e_wd   = (owner >= 0) ? wd[owner] : 32'h0;
      #1;
      if (e_cyc) s_ack = (wait_n >= 2) || ($urandom_range(0, 1) == 1);
      else       s_ack = ($urandom_range(0, 7) == 0);
      s_data_i = $urandom;
      e_ack0 = (owner == 0) && s_ack;
      e_ack1 = (owner == 1) && s_ack;
      @(negedge clk);
      n_cmp++;
      if ({s_cyc, s_stb, s_we, s_addr, s_data_o} !==
          {e_cyc, e_cyc, e_we, e_addr, e_wd}) begin
        n_bad++;
        $display("FAIL rnd_sbus: cyc %0d got %b%b%b %h %h want %b%b%b %h %h",
                 c, s_cyc, s_stb, s_we, s_addr, s_data_o,
                 e_cyc, e_cyc, e_we, e_addr, e_wd);
      end
      n_cmp++;
      if ({m0_ack, m1_ack, m0_err, m1_err} !==
          {e_ack0, e_ack1, 2'b00}) begin
        n_bad++;
        $display("FAIL rnd_ack: cyc %0d got %b want %b", c,
                 {m0_ack, m1_ack, m0_err, m1_err},
                 {e_ack0, e_ack1, 2'b00});
      end
      n_cmp++;
      if ({m0_data_o, m1_data_o} !==
          {(e_ack0 ? s_data_i : 32'h0),
           (e_ack1 ? s_data_i : 32'h0)}) begin
        n_bad++;
        $display("FAIL rnd_rdata: cyc %0d got %h %h", c,
                 m0_data_o, m1_data_o);
      end
      got[0] = e_ack0;
      got[1] = e_ack1;
      wait_n = (e_cyc && !s_ack) ? wait_n + 1 : 0;
      if (owner < 0) begin
        if (act[0] && act[1]) owner = (last == 1) ? 0 : 1;
        else if (act[1])      owner = 1;
        else if (act[0])      owner = 0;
        wait_n = 0;
      end else if (s_ack) begin
        last  = owner;
        owner = -1;
      end else if (!act[owner]) begin
        owner = -1;
      end
    end
    idle_all();
    step();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_read();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Shares one Wishbone-classic memory port between the core's instruction bus (m0) and data bus (m1).
- Used when the platform Controller exposes only a single memory bus, i.e. the second memory bus is disabled.
- Sits between the core's bus outputs and the Controller's core_* slave port.
- Registered grant FSM with round-robin fairness; optional per-transfer watchdog.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
DATA_FIRST, 1, winner on a simultaneous request when no history exists (1 = m1 data, 0 = m0 instr)
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
m0_cyc, m0_stb, m0_we  in  1 each  instruction master request
m0_addr  in  ADDR_WIDTH  instruction address
m0_data_i  in  DATA_WIDTH  instruction write data (unused by core, still muxed)
m0_data_o  out  DATA_WIDTH  read data to m0
m0_ack, m0_err  out  1 each  m0 completion / error
m1_cyc, m1_stb, m1_we  in  1 each  data master request
m1_addr  in  ADDR_WIDTH  data address
m1_data_i  in  DATA_WIDTH  data write data
m1_data_o  out  DATA_WIDTH  read data to m1
m1_ack, m1_err  out  1 each  m1 completion / error
s_cyc, s_stb, s_we  out  1 each  shared slave request
s_addr  out  ADDR_WIDTH  shared slave address
s_data_o  out  DATA_WIDTH  shared slave write data
s_data_i  in  DATA_WIDTH  shared slave read data
s_ack  in  1  shared slave acknowledge

Behaviour:
- Reset: rst is asynchronous and active-high. On rst, state=IDLE, last_grant=none, timeout counter=0.
  - All s_* outputs are 0.
  - All m*_ack and m*_err are 0.
  - m*_data_o are 0.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE transitions: req_k = mk_cyc & mk_stb.
  - Only one req_k: go to its GNT state next edge.
  - Both asserted: grant the master not in last_grant; with last_grant=none, pick per DATA_FIRST.
- Latency: request sampled in IDLE at edge N; s_cyc/s_stb asserted from cycle N+1.
- While in a GNT state:
  - s_* outputs are a combinational mux of the granted master's inputs.
  - The non-granted master's ack/err stay 0, and its data_o stays 0.
- Completion: s_ack in GNT_x drives mx_ack=1 and mx_data_o=s_data_i in the same cycle (combinational passthrough). Next state IDLE; last_grant=x.
- Throughput: minimum 2 cycles per transfer. Back-to-back transfers by the same master are allowed if the other master is idle.
- Abort: if the granted master deasserts cyc before ack, return to IDLE next edge. No ack is issued; last_grant is unchanged.
- Spurious s_ack in IDLE is ignored.
- Ack arriving in the same cycle as a new request from the other master: the ack is routed to the current owner; the new request is arbitrated from IDLE.
- Reset mid-transfer: outputs clear immediately (asynchronously); the in-flight slave cycle is abandoned.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to GNT_x and increments each cycle without s_ack.
  - When it reaches TIMEOUT_CYCLES: mx_err=1 for one cycle, s_cyc/s_stb drop, state goes to IDLE, last_grant=x.
- Undefined: no counter is built; m0_err/m1_err are tied 0; the FSM waits indefinitely for s_ack.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, GNT_I, GNT_D}
  - typedef enum logic [1:0] grant_t {NONE, INSTR, DATA}
  - localparam TIMEOUT_W=$clog2(TIMEOUT_CYCLES+1)
- Sub-module wb_arb_watchdog: counter plus expiry pulse, instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
1. m0 read only, addr 0x00000010; slave acks 1 cycle after s_stb with 0xDEADBEEF -> s_addr=0x10 from cycle N+1; m0_ack=1 with m0_data_o=0xDEADBEEF; m1_ack stays 0.
2. m0 and m1 both request from reset, DATA_FIRST=1 -> m1 (addr 0x100, we=1, data 0xA5A5A5A5) granted first; s_data_o=0xA5A5A5A5; m0 granted right after the IDLE cycle.
3. Both hold requests continuously for 6 transfers -> grants alternate D,I,D,I,D,I; no master is granted twice in a row.
4. rst pulsed while in GNT_D with s_stb=1 -> s_cyc/s_stb and all acks go 0 within the same cycle; state=IDLE; first grant after release follows DATA_FIRST.
5. m1 drops cyc 2 cycles into GNT_D, no s_ack -> IDLE next edge; no m1_ack; pending m0 granted next.
6. With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks m0 -> m0_err=1 for one cycle after 4 cycles; s_stb drops; m1 request served next. Without the macro: no err; grant held for 100 cycles.
